byte_decode_stream: RTL and testbench

Streaming ML-KEM ByteDecode_d stage. It sits directly downstream of the byte/bit packing stage.
- Consumes an 8-bit byte stream and unpacks it LSB-first into d-bit coefficients, one per output beat.
- Bit order matches bytes2bits: byte k occupies stream bits [8k +: 8].
- For D=12, each coefficient is reduced mod q=3329. Frames are 256 coefficients, flagged with last_o.

---
 rtl/mlkem_pkg.sv | 10 +
 rtl/byte_decode_stream_cond_sub_q.sv | 19 +
 rtl/byte_decode_stream.sv | 91 +++++++++
 tb/tb_byte_decode_stream.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mlkem_pkg.sv
// Shared ML-KEM constants and the coefficient type used by the decode stages.
package mlkem_pkg;

  localparam int Q        = 3329;
  localparam int N_COEFFS = 256;
  localparam int COEFF_W  = 12;

  typedef logic [COEFF_W-1:0] coeff_t;

endpackage

// File: rtl/byte_decode_stream_cond_sub_q.sv
// Single conditional subtraction of Q: maps a 12-bit raw value in [0, 4095]
// into [0, Q-1].
module cond_sub_q
  import mlkem_pkg::*;
(
  input  coeff_t a_i,
  output coeff_t y_o
);

  localparam coeff_t Q_C = coeff_t'(Q);

  // Inputs never reach 2*Q, so one subtraction fully reduces them.
  function automatic coeff_t reduce_once(input coeff_t a);
    return (a >= Q_C) ? coeff_t'(a - Q_C) : a;
  endfunction

  assign y_o = reduce_once(a_i);

endmodule

// File: rtl/byte_decode_stream.sv
// Streaming ByteDecode_d: unpacks an LSB-first byte stream into D-bit
// coefficients, reduced mod Q when D=12, framed every N_COEFFS coefficients.
module byte_decode_stream
  import mlkem_pkg::*;
#(
  parameter int D        = 12,
  parameter int N_COEFFS = mlkem_pkg::N_COEFFS,
  parameter int BUF_W    = 20
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_byte_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output coeff_t     out_coeff_o,
  output logic       out_last_o
);

  localparam logic [4:0] CNT_D    = 5'(D);
  localparam logic [7:0] LAST_IDX = 8'(N_COEFFS - 1);

  logic [BUF_W-1:0] buf_q, buf_d;
  logic [BUF_W-1:0] byte_ext;
  logic [4:0]       cnt_q, cnt_d;
  logic [7:0]       coeff_idx_q, coeff_idx_d;
  logic             accept, emit;
  logic [D-1:0]     raw;
  coeff_t           raw_ext;

  assign in_ready_o  = (cnt_q < CNT_D);
  assign out_valid_o = (cnt_q >= CNT_D);
  assign out_last_o  = out_valid_o && (coeff_idx_q == LAST_IDX);

  assign accept   = in_valid_i && in_ready_o;
  assign emit     = out_valid_o && out_ready_i;
  assign byte_ext = BUF_W'(in_byte_i);

  assign raw     = buf_q[D-1:0];
  assign raw_ext = COEFF_W'(raw);

  // Bit 0 of buf_q is the oldest stream bit; new bytes land just above the
  // valid bits, and an emitted coefficient is shifted out of the bottom.
  always_comb begin
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    coeff_idx_d = coeff_idx_q;
    case ({accept, emit})
      2'b10: begin
        buf_d = buf_q | (byte_ext << cnt_q);
        cnt_d = cnt_q + 5'd8;
      end
      2'b01: begin
        buf_d = buf_q >> D;
        cnt_d = cnt_q - CNT_D;
      end
      2'b11: begin
        buf_d = (buf_q >> D) | (byte_ext << (cnt_q - CNT_D));
        cnt_d = cnt_q + 5'd8 - CNT_D;
      end
      default: ;
    endcase
    if (emit) begin
      coeff_idx_d = out_last_o ? 8'd0 : coeff_idx_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q       <= '0;
      cnt_q       <= '0;
      coeff_idx_q <= '0;
    end else begin
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      coeff_idx_q <= coeff_idx_d;
    end
  end

  // Only the 12-bit configuration can produce values >= Q.
  if (D == COEFF_W) begin : g_reduce
    cond_sub_q u_cond_sub_q (
      .a_i (raw_ext),
      .y_o (out_coeff_o)
    );
  end else begin : g_pass
    assign out_coeff_o = raw_ext;
  end

endmodule

// File: tb/tb_byte_decode_stream.sv
// Bench for byte_decode_stream: three instances (D=12, D=1, D=4) checked
// against a bit-list ByteDecode model, constant vectors and timed sequences.
module tb_byte_decode_stream;
  import mlkem_pkg::*;

  typedef logic [7:0] byte_t;
  typedef byte_t bq_t[$];
  typedef int    cq_t[$];

  typedef struct {
    byte_t b0, b1, b2;
    int    c0, c1;
  } vec_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      iv, ir, ov, ordy, ol;
  logic [2:0][7:0] ib;
  logic [2:0][11:0] oc;

  int pass_cnt = 0;
  int chk_cnt  = 0;
  int emit_cnt [3];

  always #5 clk = ~clk;

  byte_decode_stream #(.D(12)) u_d12 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv[0]), .in_ready_o(ir[0]),
    .in_byte_i(ib[0]), .out_valid_o(ov[0]), .out_ready_i(ordy[0]),
    .out_coeff_o(oc[0]), .out_last_o(ol[0]));

  byte_decode_stream #(.D(1)) u_d1 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv[1]), .in_ready_o(ir[1]),
    .in_byte_i(ib[1]), .out_valid_o(ov[1]), .out_ready_i(ordy[1]),
    .out_coeff_o(oc[1]), .out_last_o(ol[1]));

  byte_decode_stream #(.D(4)) u_d4 (
    .clk_i(clk), .rst_i(rst), .in_valid_i(iv[2]), .in_ready_o(ir[2]),
    .in_byte_i(ib[2]), .out_valid_o(ov[2]), .out_ready_i(ordy[2]),
    .out_coeff_o(oc[2]), .out_last_o(ol[2]));

  task automatic chk(input string name, input int act, input int exp);
    chk_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  // Reference ByteDecode_d: flatten bytes into a bit list, regroup d bits at a time.
  function automatic cq_t decode(input bq_t bytes, input int d);
    cq_t r;
    int  nc;
    nc = (bytes.size() * 8) / d;
    for (int i = 0; i < nc; i++) begin
      int v;
      v = 0;
      for (int j = 0; j < d; j++) begin
        int    k;
        byte_t bb;
        k  = i * d + j;
        bb = bytes[k / 8];
        if (bb[k % 8]) v += (1 << j);
      end
      if (d == 12) v = v % Q;
      r.push_back(v);
    end
    return r;
  endfunction

  task automatic reset_all();
    @(negedge clk);
    rst  = 1'b1;
    iv   = '0;
    ordy = '0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    emit_cnt = '{0, 0, 0};
  endtask

  // Streams bytes into instance s with random valid/ready gaps, scoring each
  // emitted coefficient and the expected last flag by frame position.
  task automatic run_stream(input int s, input bq_t bytes, input cq_t exp,
                            input int vld_pct, input int rdy_pct, input string tag);
    int idx, got, cyc, limit, n;
    bit acc;
    idx = 0; got = 0; cyc = 0;
    n = bytes.size();
    limit = 50 * (n + exp.size()) + 100;
    while ((idx < n || got < exp.size()) && cyc < limit) begin
      @(negedge clk);
      cyc++;
      iv[s]   = (idx < n) && (int'($urandom_range(99)) < vld_pct);
      ib[s]   = (idx < n) ? bytes[idx] : 8'($urandom);
      ordy[s] = int'($urandom_range(99)) < rdy_pct;
      acc     = iv[s] && ir[s];
      if (ov[s] && ordy[s]) begin
        if (got < exp.size()) begin
          chk({tag, " coeff"}, int'(oc[s]), exp[got]);
          chk({tag, " last"}, int'(ol[s]), int'((emit_cnt[s] % N_COEFFS) == N_COEFFS - 1));
        end else begin
          chk({tag, " extra coeff count"}, got, exp.size());
        end
        got++;
        emit_cnt[s]++;
      end
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    iv[s]   = 1'b0;
    ordy[s] = 1'b0;
    chk({tag, " completed within budget"}, int'(idx == n && got == exp.size()), 1);
    chk({tag, " drained"}, int'(ov[s]), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t  tbl [5];
    bq_t   b;
    cq_t   e;
    byte_t a5;

    tbl[0] = '{8'h01, 8'h23, 8'h45, 'h301, 'h452};
    tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 766, 766};
    tbl[2] = '{8'h00, 8'hD0, 8'h0C, 'h000, 'h0CD};
    tbl[3] = '{8'h00, 8'h1D, 8'hD0, 3328, 0};
    tbl[4] = '{8'h34, 8'h12, 8'hAB, 'h234, 'hAB1};

    iv = '0; ordy = '0; ib = '0;
    emit_cnt = '{0, 0, 0};
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    for (int s = 0; s < 3; s++) begin
      chk("reset out_valid", int'(ov[s]), 0);
      chk("reset in_ready", int'(ir[s]), 1);
      chk("reset out_last", int'(ol[s]), 0);
      chk("reset out_coeff", int'(oc[s]), 0);
    end

    // D=12 first-coefficient latency and ordering.
    iv[0] = 1'b1; ib[0] = 8'h01; ordy[0] = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("lat valid after 1st byte", int'(ov[0]), 0);
    ib[0] = 8'h23;
    @(posedge clk); @(negedge clk);
    chk("lat valid after 2nd byte", int'(ov[0]), 1);
    chk("lat coeff0", int'(oc[0]), 'h301);
    iv[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("lat ready after emit", int'(ir[0]), 1);
    chk("lat valid after emit", int'(ov[0]), 0);
    iv[0] = 1'b1; ib[0] = 8'h45;
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0;
    chk("lat valid coeff1", int'(ov[0]), 1);
    chk("lat coeff1", int'(oc[0]), 'h452);
    @(posedge clk); @(negedge clk);
    chk("lat drained", int'(ov[0]), 0);
    ordy[0] = 1'b0;
    emit_cnt[0] += 2;

    foreach (tbl[i]) begin
      b = {tbl[i].b0, tbl[i].b1, tbl[i].b2};
      e = {tbl[i].c0, tbl[i].c1};
      run_stream(0, b, e, 100, 100, $sformatf("d12 vec%0d", i));
    end

    // D=12 backpressure: consumer stalls while a coefficient is pending.
    iv[0] = 1'b1; ib[0] = 8'h12; ordy[0] = 1'b0;
    @(posedge clk); @(negedge clk);
    ib[0] = 8'h34;
    @(posedge clk); @(negedge clk);
    ib[0] = 8'h56;
    for (int k = 0; k < 10; k++) begin
      chk("bp valid held", int'(ov[0]), 1);
      chk("bp coeff stable", int'(oc[0]), 'h412);
      chk("bp in_ready low", int'(ir[0]), 0);
      @(posedge clk); @(negedge clk);
    end
    ordy[0] = 1'b1;
    chk("bp coeff at release", int'(oc[0]), 'h412);
    @(posedge clk); @(negedge clk);
    chk("bp ready after release", int'(ir[0]), 1);
    @(posedge clk); @(negedge clk);
    iv[0] = 1'b0;
    chk("bp valid 2nd", int'(ov[0]), 1);
    chk("bp coeff 2nd (byte kept)", int'(oc[0]), 'h563);
    @(posedge clk); @(negedge clk);
    chk("bp drained", int'(ov[0]), 0);
    ordy[0] = 1'b0;
    emit_cnt[0] += 2;

    // D=1: one byte drains as eight single-bit coefficients, LSB first.
    a5 = 8'hA5;
    iv[1] = 1'b1; ib[1] = a5; ordy[1] = 1'b1;
    @(posedge clk); @(negedge clk);
    iv[1] = 1'b0;
    for (int k = 0; k < 8; k++) begin
      chk($sformatf("d1 coeff%0d", k), int'(oc[1]), int'(a5[k]));
      chk("d1 valid", int'(ov[1]), 1);
      chk("d1 in_ready low while draining", int'(ir[1]), 0);
      @(posedge clk); @(negedge clk);
    end
    chk("d1 in_ready after drain", int'(ir[1]), 1);
    chk("d1 valid after drain", int'(ov[1]), 0);
    ordy[1] = 1'b0;
    emit_cnt[1] += 8;

    // D=4: two full frames of random bytes with random stalls.
    b = {};
    for (int k = 0; k < 256; k++) b.push_back(8'($urandom));
    run_stream(2, b, decode(b, 4), 70, 60, "d4 rand");

    // D=1: random bytes crossing a frame boundary.
    b = {};
    for (int k = 0; k < 40; k++) b.push_back(8'($urandom));
    run_stream(1, b, decode(b, 1), 80, 70, "d1 rand");

    // D=12: reset in the middle of a frame discards partial state.
    b = {};
    for (int k = 0; k < 75; k++) b.push_back(8'($urandom));
    run_stream(0, b, decode(b, 12), 90, 90, "d12 pre-reset");
    iv[0] = 1'b1; ib[0] = 8'($urandom);
    @(posedge clk);
    reset_all();
    chk("midreset valid low", int'(ov[0]), 0);
    chk("midreset ready high", int'(ir[0]), 1);
    chk("midreset last low", int'(ol[0]), 0);

    b = {};
    for (int k = 0; k < 384; k++) b.push_back(8'($urandom));
    run_stream(0, b, decode(b, 12), 80, 80, "d12 frame");

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
